// File: rtl/pipe_stage_elastic_pkg.sv
// Shared types for the elastic inter-stage register.
package pipe_stage_elastic_pkg;

    // Fill level of the two-entry stage (main register, skid register).
    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_TWO   = 2'd2
    } pipe_state_t;

    // Number of entries held in a given state.
    function automatic logic [1:0] occ_of(pipe_state_t s);
        case (s)
            PS_ONE:  return 2'd1;
            PS_TWO:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_elastic_sat_counter.sv
// Saturating up-counter with synchronous clear.
module pipe_stage_elastic_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Count up on i_inc, stick at all-ones instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_inc && (r_cnt != {CNT_W{1'b1}}))
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: valid/ready handshake with a two-entry skid
// buffer, flush, sticky halt reporting and a saturating stall counter.
// in_ready depends only on registered state, so downstream back-pressure
// never reaches upstream combinationally.
module pipe_stage_elastic
    import pipe_stage_elastic_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int CNT_W      = 16,
    parameter int HALT_STOPS = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_halt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_halt,
    output logic             halted,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    pipe_state_t      r_state;
    pipe_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_main_data;
    logic             r_main_halt;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_skid_halt;
    logic             r_halted;

    logic             w_fire_in;
    logic             w_fire_out;
    logic             w_ld_main_in;
    logic             w_ld_main_skid;
    logic             w_ld_skid;
    logic             w_stall;

    assign out_valid  = (r_state != PS_EMPTY);
    assign in_ready   = (r_state != PS_TWO) && !(r_halted && (HALT_STOPS != 0));
    assign w_fire_in  = in_valid && in_ready;
    assign w_fire_out = out_valid && out_ready;

    assign out_data   = r_main_data;
    assign out_halt   = r_main_halt;
    assign halted     = r_halted;
    assign occupancy  = occ_of(r_state);

    // Next fill level and which register loads; flush drops everything,
    // including an input that would otherwise be accepted.
    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = PS_EMPTY;
        end else begin
            case (r_state)
                PS_EMPTY: begin
                    if (w_fire_in) begin
                        w_ld_main_in = 1'b1;
                        w_state_nxt  = PS_ONE;
                    end
                end
                PS_ONE: begin
                    if (w_fire_in && w_fire_out) begin
                        w_ld_main_in = 1'b1;
                    end else if (w_fire_out) begin
                        w_state_nxt  = PS_EMPTY;
                    end else if (w_fire_in) begin
                        w_ld_skid    = 1'b1;
                        w_state_nxt  = PS_TWO;
                    end
                end
                PS_TWO: begin
                    // Skid drains into main before anything newer arrives.
                    if (w_fire_out) begin
                        w_ld_main_skid = 1'b1;
                        w_state_nxt    = PS_ONE;
                    end
                end
                default: w_state_nxt = PS_EMPTY;
            endcase
        end
    end

    // Fill-level register.
    always_ff @(posedge CLK) begin
        if (RST)
            r_state <= PS_EMPTY;
        else
            r_state <= w_state_nxt;
    end

    // Payload registers load only on accepting transitions, so an idle
    // in_data never leaks into the stage.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_main_data <= '0;
            r_main_halt <= 1'b0;
            r_skid_data <= '0;
            r_skid_halt <= 1'b0;
        end else begin
            if (w_ld_main_in) begin
                r_main_data <= in_data;
                r_main_halt <= in_halt;
            end else if (w_ld_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_halt <= r_skid_halt;
            end
            if (w_ld_skid) begin
                r_skid_data <= in_data;
                r_skid_halt <= in_halt;
            end
        end
    end

    // Sticky halt: set once a halt entry is delivered (flush does not undo it).
    always_ff @(posedge CLK) begin
        if (RST)
            r_halted <= 1'b0;
        else if (w_fire_out && r_main_halt)
            r_halted <= 1'b1;
    end

    assign w_stall = out_valid && !out_ready && !flush;

    pipe_stage_elastic_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .i_clk (CLK),
        .i_rst (RST),
        .i_inc (w_stall),
        .o_cnt (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Randomised + directed bench for pipe_stage_elastic. Two instances share the
// same stimulus: A = defaults (HALT_STOPS=1, CNT_W=16), B = HALT_STOPS=0,
// CNT_W=4. Each is checked every cycle against a queue-level model.
module tb_pipe_stage_elastic;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_halt, out_ready;
    logic [31:0] in_data;

    logic        a_in_ready, a_out_valid, a_out_halt, a_halted;
    logic [31:0] a_out_data;
    logic [1:0]  a_occ;
    logic [15:0] a_stall;
    logic        b_in_ready, b_out_valid, b_out_halt, b_halted;
    logic [31:0] b_out_data;
    logic [1:0]  b_occ;
    logic [3:0]  b_stall;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.WIDTH(32), .CNT_W(16), .HALT_STOPS(1)) dut_a (
        .CLK(clk), .RST(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_halt(in_halt),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_halt(a_out_halt), .halted(a_halted), .occupancy(a_occ), .stall_cnt(a_stall)
    );

    pipe_stage_elastic #(.WIDTH(32), .CNT_W(4), .HALT_STOPS(0)) dut_b (
        .CLK(clk), .RST(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_halt(in_halt),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_halt(b_out_halt), .halted(b_halted), .occupancy(b_occ), .stall_cnt(b_stall)
    );

    // ---------------- behavioural model: a 2-deep FIFO per instance ----------
    int          m_occ    [2];
    logic [31:0] m_d      [2][2];
    logic        m_h      [2][2];
    bit          m_halted [2];
    int          m_cnt    [2];
    int          m_max    [2] = '{65535, 15};
    int          m_hs     [2] = '{1, 0};

    int nchk = 0;
    int npass = 0;

    function automatic bit m_ready(int k);
        return (m_occ[k] < 2) && !(m_halted[k] && (m_hs[k] != 0));
    endfunction

    task automatic model_edge(input int k);
        bit fo, fi;
        fo = (m_occ[k] > 0) && out_ready;
        fi = in_valid && m_ready(k);
        if (rst) begin
            m_occ[k] = 0; m_halted[k] = 0; m_cnt[k] = 0;
            m_d[k][0] = '0; m_h[k][0] = 1'b0; m_d[k][1] = '0; m_h[k][1] = 1'b0;
        end else begin
            if (!flush && (m_occ[k] > 0) && !out_ready && (m_cnt[k] < m_max[k]))
                m_cnt[k]++;
            if (fo && m_h[k][0]) m_halted[k] = 1;
            if (flush) begin
                m_occ[k] = 0;
            end else begin
                if (fo) begin
                    m_d[k][0] = m_d[k][1]; m_h[k][0] = m_h[k][1];
                    m_occ[k]--;
                end
                if (fi) begin
                    m_d[k][m_occ[k]] = in_data; m_h[k][m_occ[k]] = in_halt;
                    m_occ[k]++;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic compare_all();
        chk("A.in_ready",  {31'd0, a_in_ready},  {31'd0, m_ready(0)});
        chk("A.out_valid", {31'd0, a_out_valid}, {31'd0, m_occ[0] > 0});
        chk("A.occupancy", {30'd0, a_occ},       32'(m_occ[0]));
        chk("A.halted",    {31'd0, a_halted},    {31'd0, m_halted[0]});
        chk("A.stall_cnt", {16'd0, a_stall},     32'(m_cnt[0]));
        if (m_occ[0] > 0) begin
            chk("A.out_data", a_out_data, m_d[0][0]);
            chk("A.out_halt", {31'd0, a_out_halt}, {31'd0, m_h[0][0]});
        end
        chk("B.in_ready",  {31'd0, b_in_ready},  {31'd0, m_ready(1)});
        chk("B.out_valid", {31'd0, b_out_valid}, {31'd0, m_occ[1] > 0});
        chk("B.occupancy", {30'd0, b_occ},       32'(m_occ[1]));
        chk("B.halted",    {31'd0, b_halted},    {31'd0, m_halted[1]});
        chk("B.stall_cnt", {28'd0, b_stall},     32'(m_cnt[1]));
        if (m_occ[1] > 0) begin
            chk("B.out_data", b_out_data, m_d[1][0]);
            chk("B.out_halt", {31'd0, b_out_halt}, {31'd0, m_h[1][0]});
        end
    endtask

    // One clock: model follows the same edge as the DUTs, compare on negedge.
    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        compare_all();
    endtask

    // Offer a word until instance A takes it (bounded).
    task automatic send(input logic [31:0] d, input logic h);
        bit acc;
        in_valid = 1'b1; in_data = d; in_halt = h;
        for (int t = 0; t < 20; t++) begin
            acc = m_ready(0);
            step();
            if (acc) begin
                in_valid = 1'b0; in_halt = 1'b0;
                return;
            end
        end
        chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0; in_halt = 1'b0;
    endtask

    int saved_stall;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_halt = 1'b0;
        out_ready = 1'b0; in_data = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_occ",      {30'd0, a_occ},        32'd0);
        chk("rst_in_ready", {31'd0, a_in_ready},   32'd1);
        chk("rst_out_data", a_out_data,            32'd0);
        chk("rst_stall",    {16'd0, a_stall},      32'd0);

        // Streaming: one word per cycle, 1-cycle latency, occupancy 1.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 32'(i);
            step();
            chk("stream_data", a_out_data, 32'(i));
            chk("stream_occ",  {30'd0, a_occ}, 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_stall", {16'd0, a_stall}, 32'd0);

        // Back-pressure into the skid.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA; step();
        in_data = 32'hB; step();
        chk("skid_occ",      {30'd0, a_occ},      32'd2);
        chk("skid_in_ready", {31'd0, a_in_ready}, 32'd0);
        in_data = 32'hC; step(); step();
        chk("skid_stall",    {16'd0, a_stall},    32'd3);
        chk("skid_head",     a_out_data,          32'hA);
        out_ready = 1'b1; step();
        chk("drain_B",       a_out_data,          32'hB);
        step();
        chk("drain_C",       a_out_data,          32'hC);
        in_valid = 1'b0; step();
        chk("drain_empty",   {30'd0, a_occ},      32'd0);

        // Flush while full with a word on the input.
        out_ready = 1'b0;
        send(32'h11, 1'b0); send(32'h12, 1'b0);
        saved_stall = m_cnt[0];
        in_valid = 1'b1; in_data = 32'hD; flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_occ",   {30'd0, a_occ},       32'd0);
        chk("flush_valid", {31'd0, a_out_valid}, 32'd0);
        chk("flush_stall", {16'd0, a_stall},     32'(saved_stall));
        out_ready = 1'b1; step(); step();

        // Halt: 0x7 is already held when 0x6 leaves, so it still drains.
        send(32'h5, 1'b0); send(32'h6, 1'b1);
        in_valid = 1'b1; in_data = 32'h7; step(); in_valid = 1'b0;
        chk("halt_A",       {31'd0, a_halted},   32'd1);
        chk("halt_B",       {31'd0, b_halted},   32'd1);
        chk("halt_A_ready", {31'd0, a_in_ready}, 32'd0);
        chk("halt_B_ready", {31'd0, b_in_ready}, 32'd1);
        chk("halt_7_held",  a_out_data,          32'h7);
        step();
        in_valid = 1'b1; in_data = 32'h8; step(); step(); in_valid = 1'b0;
        chk("halt_A_blocks", {30'd0, a_occ},     32'd0);
        step();

        // Saturation on the 4-bit counter.
        rst = 1'b1; step(); rst = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h33; step(); in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("sat_B", {28'd0, b_stall}, 32'd15);
        chk("sat_A", {16'd0, a_stall}, 32'd20);

        // Reset mid-operation with B full and halted.
        rst = 1'b1; step(); rst = 1'b0;
        send(32'h44, 1'b1); send(32'h45, 1'b0);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h46; step();
        out_ready = 1'b0; step(); in_valid = 1'b0;
        chk("mid_B_occ",    {30'd0, b_occ},    32'd2);
        chk("mid_B_halted", {31'd0, b_halted}, 32'd1);
        chk("mid_A_halted", {31'd0, a_halted}, 32'd1);
        rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD; step();
        rst = 1'b0; in_valid = 1'b0;
        chk("rst2_B_occ",   {30'd0, b_occ},      32'd0);
        chk("rst2_B_halt",  {31'd0, b_halted},   32'd0);
        chk("rst2_A_ready", {31'd0, a_in_ready}, 32'd1);
        chk("rst2_B_data",  b_out_data,          32'd0);
        chk("rst2_B_stall", {28'd0, b_stall},    32'd0);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h9; step(); in_valid = 1'b0;
        chk("post_rst_valid", {31'd0, a_out_valid}, 32'd1);
        chk("post_rst_data",  a_out_data,           32'h9);
        step();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            flush     = ($urandom_range(0, 29) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_halt   = ($urandom_range(0, 39) == 0);
            in_data   = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque WIDTH-bit payload plus a halt flag between two pipeline stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure does not combinationally couple upstream ready to downstream ready.
- Adds flush, a sticky halt latch and a saturating stall counter; the old ihit/dhit enable pair is replaced by the handshake.

Parameters:
- WIDTH, 32, payload bits per entry (one packed pipeline-register bundle).
- CNT_W, 16, width of the stall-cycle counter.
- HALT_STOPS, 1, when 1 the block refuses new input after a halt entry leaves; when 0 halt is only reported.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RST  input  1  reset, synchronous, active-high.
- flush  input  1  discard all held entries and the current input.
- in_valid  input  1  upstream has a payload.
- in_ready  output  1  block accepts this cycle; registered.
- in_data  input  WIDTH  upstream payload.
- in_halt  input  1  payload is a halt instruction.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts head.
- out_data  output  WIDTH  head payload (main register).
- out_halt  output  1  halt flag of head.
- halted  output  1  sticky: a halt entry has left the block.
- occupancy  output  2  entries held: 0, 1 or 2.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Handshakes:
  - fire_in = in_valid & in_ready.
  - fire_out = out_valid & out_ready.
- Storage: main register (drives out_*) and skid register, each holding data and halt.
- States:
  - EMPTY (occupancy 0).
  - ONE (main full).
  - TWO (main and skid full).
- out_valid = (state != EMPTY).
- in_ready = (state != TWO) & !(halted & HALT_STOPS), taken from registered state only.
- Transitions, when flush=0:
  - EMPTY: fire_in -> main<=in, go to ONE.
  - ONE: fire_in & fire_out -> main<=in, stay ONE. fire_out only -> EMPTY. fire_in only -> skid<=in, go to TWO. Neither -> hold.
  - TWO: fire_out -> main<=skid, go to ONE. No input is accepted in TWO.
- Latency:
  - 1 cycle from fire_in to out_valid when the block was EMPTY.
  - Order is strictly FIFO: skid always drains into main before any newer entry.
- Flush (priority below RST, above everything else):
  - Next state is EMPTY and the input that cycle is dropped, even though in_ready may read 1.
  - Any fire_out in the same cycle is still counted as delivered.
  - halted and stall_cnt are not cleared by flush.
- Halt:
  - On fire_out with out_halt=1, halted<=1 from the next cycle; it stays 1 until RST.
  - If HALT_STOPS=1, in_ready is 0 from that cycle on.
  - Entries already held still drain normally.
- stall_cnt:
  - Increments each cycle out_valid & !out_ready.
  - Holds at 2^CNT_W-1.
  - Does not increment in a cycle where flush=1.
- Reset (RST=1 at a clock edge, including mid-transfer):
  - state EMPTY, out_valid 0, in_ready 1 from the following cycle, occupancy 0, halted 0, stall_cnt 0.
  - out_data/out_halt read 0; skid register cleared to 0.
- Payload data registers load only on an accepting transition; no X-propagation from an idle in_data.

Decomposition:
- cpu_types_pkg: add typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_TWO} pipe_state_t.
- The stage-specific packed structs (e.g. a MEM/WB bundle) live in the same package; integrating stages instantiate with WIDTH=$bits(<struct>).
- Interface pipe_stage_if in include/pipe_stage_if.vh, with modports stage and tb.
- Optional sub-module sat_counter (CNT_W parameter, inc/clear inputs) for stall_cnt; the rest stays flat.

Test Plan:
- Streaming: out_ready=1, in_valid=1 for 8 cycles with data 0x1..0x8 -> out_data 0x1..0x8 on consecutive cycles starting 1 cycle after first fire; occupancy stays 1; stall_cnt=0.
- Back-pressure/skid: load 0xA, then out_ready=0 while offering 0xB then 0xC -> 0xB accepted, occupancy=2, in_ready=0 next cycle, 0xC held upstream. Raise out_ready -> outputs 0xA, 0xB, 0xC in order; stall_cnt equals the number of stalled cycles.
- Flush in TWO with in_valid=1 data 0xD -> next cycle out_valid=0, occupancy=0; 0xD never appears; stall_cnt unchanged by the flush cycle.
- Halt: send 0x5, then 0x6 with in_halt=1, then 0x7 -> after 0x6 fires out, halted=1 and in_ready=0 (HALT_STOPS=1). 0x7 only appears if it was already held. With HALT_STOPS=0, 0x7 flows and halted=1.
- Saturation: CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15, no wrap.
- Reset mid-operation: assert RST in TWO with halted=1 -> next cycle all outputs at reset values and in_ready=1; a new entry 0x9 then passes with 1-cycle latency.
